// File: rtl/text_console_ctrl.sv
// =============================================================================
// Module   : text_console_ctrl
// Purpose  : Byte-stream text console; owns the cursor and drives the text-RAM
//            write port, including clear-line / clear-screen fill sweeps.
//            Optional macro AUTO_CLEAR_EN: reset exits into a full-screen wipe.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module text_console_ctrl #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [7:0]  data_out,
    output logic [11:0] write_address,
    output logic        w_en,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CLR_LINE   = 2'd1,
        S_CLR_SCREEN = 2'd2
    } state_t;

    localparam logic [11:0] C_COLS        = 12'(COLS);
    localparam logic [11:0] C_LINE_LAST   = 12'(COLS - 1);
    localparam logic [11:0] C_SCREEN_LAST = 12'(COLS * ROWS - 1);
    localparam logic [6:0]  C_COL_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  C_ROW_LAST    = 5'(ROWS - 1);
`ifdef AUTO_CLEAR_EN
    localparam state_t      C_RESET_STATE = S_CLR_SCREEN;
`else
    localparam state_t      C_RESET_STATE = S_IDLE;
`endif

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [11:0] sweep_q, sweep_d;
    logic        we_q, we_d;
    logic [7:0]  data_q, data_d;
    logic [11:0] addr_q, addr_d;

    logic [11:0] row_base;
    logic [11:0] cur_addr;
    logic        do_newline;

    assign row_base = 12'(row_q) * C_COLS;
    assign cur_addr = row_base + {5'd0, col_q};

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        sweep_d    = sweep_q;
        we_d       = 1'b0;
        data_d     = data_q;
        addr_d     = addr_q;
        do_newline = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (char_valid) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        we_d   = 1'b1;
                        data_d = char_in;
                        addr_d = cur_addr;
                        if (col_q == C_COL_LAST) begin
                            do_newline = 1'b1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            8'h0A: do_newline = 1'b1;
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    col_d  = col_q - 7'd1;
                                    we_d   = 1'b1;
                                    data_d = FILL_CHAR;
                                    addr_d = cur_addr - 12'd1;
                                end
                            end
                            8'h0C: begin
                                row_d   = 5'd0;
                                col_d   = 7'd0;
                                sweep_d = 12'd0;
                                state_d = S_CLR_SCREEN;
                            end
                            default: ;
                        endcase
                    end

                    // Wrap to the top instead of scrolling; the new row is wiped.
                    if (do_newline) begin
                        col_d   = 7'd0;
                        row_d   = (row_q == C_ROW_LAST) ? 5'd0 : row_q + 5'd1;
                        sweep_d = 12'd0;
                        state_d = S_CLR_LINE;
                    end
                end
            end

            S_CLR_LINE: begin
                we_d   = 1'b1;
                data_d = FILL_CHAR;
                addr_d = row_base + sweep_q;
                if (sweep_q == C_LINE_LAST) begin
                    sweep_d = 12'd0;
                    state_d = S_IDLE;
                end else begin
                    sweep_d = sweep_q + 12'd1;
                end
            end

            S_CLR_SCREEN: begin
                we_d   = 1'b1;
                data_d = FILL_CHAR;
                addr_d = sweep_q;
                if (sweep_q == C_SCREEN_LAST) begin
                    sweep_d = 12'd0;
                    state_d = S_IDLE;
                end else begin
                    sweep_d = sweep_q + 12'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_RESET_STATE;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            sweep_q <= 12'd0;
            we_q    <= 1'b0;
            data_q  <= 8'd0;
            addr_q  <= 12'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sweep_q <= sweep_d;
            we_q    <= we_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign char_ready    = (state_q == S_IDLE);
    assign busy          = ~char_ready;
    assign w_en          = we_q;
    assign data_out      = data_q;
    assign write_address = addr_q;
    assign cursor_row    = row_q;
    assign cursor_col    = col_q;

endmodule

`default_nettype wire
